// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit instruction word,
// rejects out-of-range immediates, and tags each legal word with an auto-incrementing address.
module inst_encoder #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_valid,
    output logic [15:0]       err_count
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_ISH = 3'd2;
    localparam logic [2:0] FMT_S   = 3'd3;
    localparam logic [2:0] FMT_SB  = 3'd4;
    localparam logic [2:0] FMT_U   = 3'd5;
    localparam logic [2:0] FMT_UJ  = 3'd6;

    logic              r_out_valid;
    logic [31:0]       r_out_inst;
    logic [ADDR_W-1:0] r_out_addr;
    logic [ADDR_W-1:0] r_next_addr;
    logic              r_err_valid;
    logic [15:0]       r_err_count;

    logic        w_accept;
    logic        w_legal;
    logic [31:0] w_inst;

    assign in_ready  = !clear && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;

    assign out_valid = r_out_valid;
    assign out_inst  = r_out_inst;
    assign out_addr  = r_out_addr;
    assign err_valid = r_err_valid;
    assign err_count = r_err_count;

    // Field packing and immediate range check for the request at the input.
    always_comb begin
        w_inst  = 32'h0000_0000;
        w_legal = 1'b0;
        case (in_fmt)
            FMT_R: begin
                w_inst  = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
                w_legal = 1'b1;
            end
            FMT_I: begin
                w_inst  = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                w_legal = (in_imm[31:11] == {21{in_imm[11]}});
            end
            FMT_ISH: begin
                w_inst  = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
                w_legal = (in_imm[31:5] == 27'd0);
            end
            FMT_S: begin
                w_inst  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                w_legal = (in_imm[31:11] == {21{in_imm[11]}});
            end
            FMT_SB: begin
                w_inst  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:1], in_imm[11], in_opcode};
                // 13-bit signed and even: [-4096, 4094]
                w_legal = (in_imm[31:12] == {20{in_imm[12]}}) && (in_imm[0] == 1'b0);
            end
            FMT_U: begin
                w_inst  = {in_imm[31:12], in_rd, in_opcode};
                w_legal = (in_imm[11:0] == 12'h000);
            end
            FMT_UJ: begin
                w_inst  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                w_legal = (in_imm[31:20] == {12{in_imm[20]}}) && (in_imm[0] == 1'b0);
            end
            default: begin
                w_inst  = 32'h0000_0000;
                w_legal = 1'b0;
            end
        endcase
    end

    // Output word, address counter and error bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_inst  <= 32'h0000_0000;
            r_out_addr  <= BASE_ADDR;
            r_next_addr <= BASE_ADDR;
            r_err_valid <= 1'b0;
            r_err_count <= 16'h0000;
        end else if (clear) begin
            r_out_valid <= 1'b0;
            r_next_addr <= BASE_ADDR;
            r_err_valid <= 1'b0;
            r_err_count <= 16'h0000;
        end else begin
            r_err_valid <= w_accept && !w_legal;
            if (w_accept && w_legal) begin
                r_out_valid <= 1'b1;
                r_out_inst  <= w_inst;
                r_out_addr  <= r_next_addr;
                r_next_addr <= r_next_addr + ADDR_W'(3'd4);
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end else begin
                r_out_valid <= r_out_valid;
            end
            if (w_accept && !w_legal && (r_err_count != 16'hFFFF)) begin
                r_err_count <= r_err_count + 16'd1;
            end else begin
                r_err_count <= r_err_count;
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed self-checking bench for inst_encoder: encodings, stream addressing,
// backpressure, immediate rejection, clear and asynchronous reset.
module tb_inst_encoder;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_addr;
    logic        err_valid;
    logic [15:0] err_count;

    int n_pass;
    int n_total;

    inst_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_addr  (out_addr),
        .err_valid (err_valid),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm);
        in_valid  = 1'b1;
        in_fmt    = fmt;
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
    endtask

    // Present a request, take one edge, and check the emitted word.
    task automatic send_word(input string tag, input logic [2:0] fmt, input logic [6:0] op,
                             input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                             input logic [31:0] exp_inst, input logic [31:0] exp_addr);
        drive(fmt, op, rd, rs1, rs2, f3, f7, imm);
        tick();
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_inst"}, out_inst, exp_inst);
        check({tag, "_addr"}, out_addr, exp_addr);
    endtask

    // Present an illegal request and check the error pulse/count.
    task automatic send_bad(input string tag, input logic [2:0] fmt, input logic [6:0] op,
                            input logic [31:0] imm, input logic [15:0] exp_cnt);
        drive(fmt, op, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, imm);
        tick();
        check({tag, "_errv"}, {31'd0, err_valid}, 32'd1);
        check({tag, "_errc"}, {16'd0, err_count}, {16'd0, exp_cnt});
        check({tag, "_nowrd"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_addr"}, out_addr, 32'h0000_0004);
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst_n     = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        drive(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        in_valid  = 1'b0;
        #12;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_inst", out_inst, 32'h0000_0000);
        check("rst_addr", out_addr, 32'h0000_0000);
        check("rst_errv", {31'd0, err_valid}, 32'd0);
        check("rst_errc", {16'd0, err_count}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single addi
        send_word("addi", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 32'h0);
        in_valid = 1'b0;
        tick();
        check("addi_drain", {31'd0, out_valid}, 32'd0);

        // Clear alone resets the address counter
        clear = 1'b1;
        #1;
        check("clr_ready", {31'd0, in_ready}, 32'd0);
        tick();
        clear = 1'b0;

        // Back-to-back stream
        send_word("sw",   3'd3, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020_A423, 32'h0);
        send_word("beq",  3'd4, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 32'h4);
        send_word("lui",  3'd5, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 32'h8);
        send_word("jal",  3'd6, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h0010_00EF, 32'hC);
        send_word("srai", 3'd2, 7'h13, 5'd3, 5'd3, 5'd0, 3'd5, 7'h20, 32'd4, 32'h4041_D193, 32'h10);
        send_word("add",  3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'hDEAD_BEEF, 32'h0020_81B3, 32'h14);
        in_valid = 1'b0;
        tick();
        check("strm_drain", {31'd0, out_valid}, 32'd0);

        // Backpressure
        out_ready = 1'b0;
        send_word("bp_ld", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 32'h18);
        drive(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0);
        #1;
        check("bp_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_inst", out_inst, 32'h0050_0093);
            check("bp_hold_addr", out_addr, 32'h18);
        end
        out_ready = 1'b1;
        #1;
        check("bp_ready_up", {31'd0, in_ready}, 32'd1);
        tick();
        check("bp_reload_inst", out_inst, 32'h4020_81B3);
        check("bp_reload_addr", out_addr, 32'h1C);
        in_valid = 1'b0;

        clear = 1'b1;
        tick();
        clear = 1'b0;

        // Two legal words, then illegal immediates
        send_word("addi_min", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800, 32'h8000_0093, 32'h0);
        send_word("add2", 3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0, 32'h0020_81B3, 32'h4);
        send_bad("bad_addi", 3'd1, 7'h13, 32'd2048, 16'd1);
        send_bad("bad_beq",  3'd4, 7'h63, 32'd3, 16'd2);
        send_bad("bad_lui",  3'd5, 7'h37, 32'd1, 16'd3);
        send_bad("bad_shft", 3'd2, 7'h13, 32'd32, 16'd4);
        send_bad("bad_fmt7", 3'd7, 7'h13, 32'd0, 16'd5);
        send_word("after_bad", 3'd4, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4094, 32'h7E00_0FE3, 32'h8);
        check("after_bad_errv", {31'd0, err_valid}, 32'd0);
        check("after_bad_errc", {16'd0, err_count}, 32'd5);

        // Clear together with a valid request
        drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        clear = 1'b1;
        #1;
        check("clr_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        check("clr_valid", {31'd0, out_valid}, 32'd0);
        check("clr_errc", {16'd0, err_count}, 32'd0);
        drive(3'd5, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        tick();
        check("clr_bad_errc", {16'd0, err_count}, 32'd1);
        send_word("clr_w0", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 32'h0);
        send_word("clr_w1", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 32'h4);
        in_valid = 1'b0;

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_addr", out_addr, 32'h0);
        check("arst_errc", {16'd0, err_count}, 32'd0);
        check("arst_inst", out_inst, 32'h0);
        rst_n = 1'b1;
        tick();
        send_word("post_rst", 3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0, 32'h0020_81B3, 32'h0);
        in_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Streaming RISC-V RV32I instruction encoder: the inverse of the core's immediate decode path.
- Accepts decoded fields (format, opcode, registers, funct fields, full 32-bit immediate), range-checks the immediate, packs a 32-bit instruction word, and emits it with an auto-incrementing instruction-memory address.
- Used by the program loader / self-test sequencer to fill instruction memory before the core is released.
- Single-stage registered pipeline with valid/ready on both sides.

Parameters:
BASE_ADDR, 32'h0000_0000, address of the first emitted instruction after reset or clear
ADDR_W, 32, width of out_addr

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous: reset address counter and error count, drop pending output
in_valid  input  1  request valid
in_ready  output  1  encoder can accept request
in_fmt  input  3  0=R, 1=I, 2=I-shift, 3=S, 4=SB, 5=U, 6=UJ, 7=reserved
in_opcode  input  7  placed verbatim in inst[6:0]
in_rd  input  5  destination register
in_rs1  input  5  source register 1
in_rs2  input  5  source register 2
in_funct3  input  3  funct3
in_funct7  input  7  funct7 (R and I-shift only)
in_imm  input  32  immediate, signed byte value (U: full upper value)
out_valid  output  1  encoded word valid
out_ready  input  1  downstream accepts word
out_inst  output  32  encoded instruction
out_addr  output  ADDR_W  byte address of out_inst
err_valid  output  1  one-cycle pulse: last accepted request rejected
err_count  output  16  saturating count of rejected requests

Behaviour:
- Reset (rst_n low, async): out_valid=0, out_inst=0, out_addr=BASE_ADDR, err_valid=0, err_count=0, internal next-address=BASE_ADDR.
- Handshake: in_ready = !out_valid || out_ready (combinational). A request is accepted on a rising edge with in_valid && in_ready. Output registers load on the edge after acceptance (latency 1). Full throughput with out_ready held high.
- out_inst/out_addr hold stable while out_valid && !out_ready. out_valid drops after a handshake unless a new valid word loads on the same edge.
- Packing (fields not listed are 0):
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - I-shift: {funct7, imm[4:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - SB: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - UJ: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- Legality; the request is rejected if:
  - I or S: imm is not in [-2048, 2047].
  - I-shift: imm is not in [0, 31].
  - SB: imm is not in [-4096, 4094], or imm[0]=1.
  - U: imm[11:0] != 0.
  - UJ: imm is not in [-1048576, 1048574], or imm[0]=1.
  - in_fmt=7.
  - R never rejects; imm is ignored.
- Rejected request: still consumes a handshake. No word is emitted; out_valid is unchanged except for the normal drain of the held word. err_valid pulses 1 cycle (the edge after acceptance). err_count increments, saturating at 16'hFFFF. Address does not advance.
- Address: each legal word takes out_addr = next-address, then next-address += 4, wrapping modulo 2^ADDR_W.
- clear: has priority over any handshake in the same cycle. The request presented that cycle is not accepted; in_ready is forced 0 during clear. Effects on the next edge: out_valid=0, next-address=BASE_ADDR, err_count=0, err_valid=0.
- Reset asserted mid-stream discards the pending word immediately (async).

Test Plan:
- I-type addi x1,x0,5 (fmt1, op 0x13, f3 0, imm 5) with out_ready=1 -> next cycle out_valid=1, out_inst=0x00500093, out_addr=0x0.
- Back-to-back stream, out_ready=1:
  - sw x2,8(x1) -> 0x0020A423 @0x0.
  - beq x0,x0,-4 -> 0xFE000EE3 @0x4.
  - lui x5,0x12345000 -> 0x123452B7 @0x8.
  - jal x1,2048 -> 0x001000EF @0xC.
  - srai x3,x3,4 (f7 0x20, f3 5) -> 0x4041D193 @0x10.
  - One word per cycle, no bubbles.
- Backpressure: hold out_ready=0 with out_valid=1 -> in_ready=0; out_inst and out_addr stable for 5 cycles. Raise out_ready with a new request valid -> handshake and reload on the same edge.
- Illegal immediates, after 2 legal words:
  - addi imm=2048 -> err_valid pulse, err_count=1, no word, out_addr not advanced.
  - beq imm=3 (odd) -> err_count=2.
  - lui imm=0x1 -> err_count=3.
  - Next legal word goes to 0x8.
- clear asserted together with in_valid -> request not accepted; next cycle out_valid=0, err_count=0. Following legal word goes to BASE_ADDR.
- rst_n pulled low mid-stream (out_valid=1, between edges) -> outputs reset immediately: out_valid=0, out_addr=BASE_ADDR, err_count=0.
